// File: rtl/time_set_ctrl.sv
// ---------------------------------------------------------------------------
// TimeSetCtrl: control block for the clock/calendar display datapath.
//
// Chooses between the time and date views of the display, blanks digits, and
// runs a three-button edit session. Entering an edit session snapshots the
// live time/date into shadow registers and halts the time counter. The user
// then steps through the fields and increments them with calendar-correct
// wrap. The session ends with a one-cycle load strobe carrying the edited
// values, or with an abort that leaves the counter untouched.
//
// Ports
//   clk        in   system clock, all logic on rising edge
//   rst_n      in   asynchronous active-low reset
//   btn_mode   in   debounced level: view toggle / edit abort
//   btn_sel    in   debounced level: enter edit / next field / commit
//   btn_inc    in   debounced level: increment selected field
//   cur_*      in   live sec/min/hour/day/month/year from the time counter
//   run_en     out  1 = time counter may advance (0 while editing)
//   set_valid  out  one-cycle load strobe for the set_* values
//   set_*      out  edited values (shadow registers)
//   show_date  out  0 = time layout, 1 = date layout
//   blank_mask out  1 = digit blanked, bit 7 = leftmost digit
// ---------------------------------------------------------------------------
module time_set_ctrl #(
   parameter int BLINK_DIV = 25000000,
   parameter int YEAR_MIN  = 2000,
   parameter int YEAR_MAX  = 2099
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        btn_mode,
   input  logic        btn_sel,
   input  logic        btn_inc,
   input  logic [5:0]  cur_sec,
   input  logic [5:0]  cur_min,
   input  logic [4:0]  cur_hour,
   input  logic [4:0]  cur_day,
   input  logic [3:0]  cur_month,
   input  logic [11:0] cur_year,
   output logic        run_en,
   output logic        set_valid,
   output logic [5:0]  set_sec,
   output logic [5:0]  set_min,
   output logic [4:0]  set_hour,
   output logic [4:0]  set_day,
   output logic [3:0]  set_month,
   output logic [11:0] set_year,
   output logic        show_date,
   output logic [7:0]  blank_mask
);

   localparam int BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
   localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);
   localparam logic [11:0] YR_MIN = 12'(YEAR_MIN);
   localparam logic [11:0] YR_MAX = 12'(YEAR_MAX);

   typedef enum logic [1:0] {
      RUN_TIME = 2'd0,
      RUN_DATE = 2'd1,
      EDIT     = 2'd2
   } state_e;

   typedef enum logic [2:0] {
      F_HOUR  = 3'd0,
      F_MIN   = 3'd1,
      F_SEC   = 3'd2,
      F_DAY   = 3'd3,
      F_MONTH = 3'd4,
      F_YEAR  = 3'd5
   } field_e;

   state_e state_q, state_d;
   field_e field_q, field_d;

   logic modePrev_q, selPrev_q, incPrev_q;
   logic modeRise, selRise, incRise;
   logic inEdit, loadShadows, doInc, doCommit, blinkRestart;

   logic        setValid_q, setValid_d;
   logic [5:0]  secShadow_q,   secShadow_d;
   logic [5:0]  minShadow_q,   minShadow_d;
   logic [4:0]  hourShadow_q,  hourShadow_d;
   logic [4:0]  dayShadow_q,   dayShadow_d;
   logic [3:0]  monthShadow_q, monthShadow_d;
   logic [11:0] yearShadow_q,  yearShadow_d;

   logic [BLINK_W-1:0] blinkCnt_q, blinkCnt_d;
   logic               blinkPhase_q, blinkPhase_d;

   logic [3:0]  monthNext;
   logic [11:0] yearNext;
   logic [4:0]  dimCur, dimMonthNext, dimYearNext;

   // Days in a month. Months outside 1..12 can only come from an out-of-range
   // snapshot; they get 31 so the day field never wraps early.
   function automatic logic [4:0] daysInMonth(input logic [3:0] month,
                                              input logic [11:0] year);
      logic [4:0] dim;
      case (month)
         4'd2:                    dim = (year[1:0] == 2'b00) ? 5'd29 : 5'd28;
         4'd4, 4'd6, 4'd9, 4'd11: dim = 5'd30;
         default:                 dim = 5'd31;
      endcase
      return dim;
   endfunction

   // Edge detection with a fixed priority mode > sel > inc. Only one rise is
   // acted on per cycle; the lower-priority ones are simply dropped.
   always_comb begin
      modeRise = btn_mode & ~modePrev_q;
      selRise  = btn_sel  & ~selPrev_q & ~modeRise;
      incRise  = btn_inc  & ~incPrev_q & ~modeRise & ~selRise;
   end

   // Event decode shared by the FSM, the shadow registers and the blink timer.
   always_comb begin
      inEdit       = (state_q == EDIT);
      loadShadows  = ~inEdit & selRise;
      doInc        = inEdit & incRise;
      doCommit     = inEdit & selRise & (field_q == F_YEAR);
      blinkRestart = loadShadows | (inEdit & (selRise | incRise));
   end

   // The prev registers reset to 1 so a button held through reset has to be
   // released and pressed again before it counts.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         modePrev_q <= 1'b1;
         selPrev_q  <= 1'b1;
         incPrev_q  <= 1'b1;
      end else begin
         modePrev_q <= btn_mode;
         selPrev_q  <= btn_sel;
         incPrev_q  <= btn_inc;
      end
   end

   // FSM state register: view/edit state plus the field being edited.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= RUN_TIME;
         field_q <= F_HOUR;
      end else begin
         state_q <= state_d;
         field_q <= field_d;
      end
   end

   // FSM next-state logic. Abort and commit both return to the time view.
   always_comb begin
      state_d = state_q;
      field_d = field_q;
      case (state_q)
         RUN_TIME, RUN_DATE: begin
            if (modeRise) begin
               state_d = (state_q == RUN_TIME) ? RUN_DATE : RUN_TIME;
            end else if (selRise) begin
               state_d = EDIT;
               field_d = F_HOUR;
            end
         end
         EDIT: begin
            if (modeRise) begin
               state_d = RUN_TIME;
            end else if (selRise) begin
               if (field_q == F_YEAR) begin
                  state_d = RUN_TIME;
               end else begin
                  field_d = field_e'(field_q + 3'd1);
               end
            end
         end
         default: begin
            state_d = RUN_TIME;
            field_d = F_HOUR;
         end
      endcase
   end

   // Wrap targets for month and year plus the month lengths the day field
   // needs, both for its own wrap and for clamping after month/year edits.
   always_comb begin
      monthNext = ((monthShadow_q == 4'd0) || (monthShadow_q >= 4'd12)) ?
                  4'd1 : monthShadow_q + 4'd1;
      yearNext  = ((yearShadow_q < YR_MIN) || (yearShadow_q >= YR_MAX)) ?
                  YR_MIN : yearShadow_q + 12'd1;
      dimCur       = daysInMonth(monthShadow_q, yearShadow_q);
      dimMonthNext = daysInMonth(monthNext, yearShadow_q);
      dimYearNext  = daysInMonth(monthShadow_q, yearNext);
   end

   // Shadow register next values: snapshot on entering edit, otherwise
   // increment the selected field. Out-of-range values fall to the field
   // minimum through the >= / == 0 tests.
   always_comb begin
      secShadow_d   = secShadow_q;
      minShadow_d   = minShadow_q;
      hourShadow_d  = hourShadow_q;
      dayShadow_d   = dayShadow_q;
      monthShadow_d = monthShadow_q;
      yearShadow_d  = yearShadow_q;
      if (loadShadows) begin
         secShadow_d   = cur_sec;
         minShadow_d   = cur_min;
         hourShadow_d  = cur_hour;
         dayShadow_d   = cur_day;
         monthShadow_d = cur_month;
         yearShadow_d  = cur_year;
      end else if (doInc) begin
         case (field_q)
            F_HOUR:  hourShadow_d = (hourShadow_q >= 5'd23) ? 5'd0 : hourShadow_q + 5'd1;
            F_MIN:   minShadow_d  = (minShadow_q >= 6'd59) ? 6'd0 : minShadow_q + 6'd1;
            F_SEC:   secShadow_d  = (secShadow_q >= 6'd59) ? 6'd0 : secShadow_q + 6'd1;
            F_DAY:   dayShadow_d  = ((dayShadow_q == 5'd0) || (dayShadow_q >= dimCur)) ?
                                    5'd1 : dayShadow_q + 5'd1;
            F_MONTH: begin
               monthShadow_d = monthNext;
               dayShadow_d   = (dayShadow_q > dimMonthNext) ? dimMonthNext : dayShadow_q;
            end
            F_YEAR: begin
               yearShadow_d = yearNext;
               dayShadow_d  = (dayShadow_q > dimYearNext) ? dimYearNext : dayShadow_q;
            end
            default: begin
            end
         endcase
      end
   end

   // Blink timer: free-running half-period counter, restarted visible on
   // every edit interaction so the user sees the field right after a press.
   always_comb begin
      blinkCnt_d   = blinkCnt_q + 1'b1;
      blinkPhase_d = blinkPhase_q;
      if (blinkRestart) begin
         blinkCnt_d   = '0;
         blinkPhase_d = 1'b1;
      end else if (blinkCnt_q == BLINK_LAST) begin
         blinkCnt_d   = '0;
         blinkPhase_d = ~blinkPhase_q;
      end
   end

   always_comb begin
      setValid_d = doCommit;
   end

   // Datapath registers: shadows, commit strobe and blink timer. The strobe
   // is high for exactly the cycle after the commit press.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         secShadow_q   <= 6'd0;
         minShadow_q   <= 6'd0;
         hourShadow_q  <= 5'd0;
         dayShadow_q   <= 5'd1;
         monthShadow_q <= 4'd1;
         yearShadow_q  <= YR_MIN;
         setValid_q    <= 1'b0;
         blinkCnt_q    <= '0;
         blinkPhase_q  <= 1'b1;
      end else begin
         secShadow_q   <= secShadow_d;
         minShadow_q   <= minShadow_d;
         hourShadow_q  <= hourShadow_d;
         dayShadow_q   <= dayShadow_d;
         monthShadow_q <= monthShadow_d;
         yearShadow_q  <= yearShadow_d;
         setValid_q    <= setValid_d;
         blinkCnt_q    <= blinkCnt_d;
         blinkPhase_q  <= blinkPhase_d;
      end
   end

   // FSM output logic: layout select and digit blanking. Time layout leaves
   // digits 3-2 dark; the selected field's digits go dark in the off phase.
   always_comb begin
      logic [7:0] fieldMask;
      run_en    = ~inEdit;
      show_date = (state_q == RUN_DATE) ||
                  (inEdit && ((field_q == F_DAY) || (field_q == F_MONTH) ||
                              (field_q == F_YEAR)));
      case (field_q)
         F_HOUR, F_DAY:  fieldMask = 8'b1100_0000;
         F_MIN, F_MONTH: fieldMask = 8'b0011_0000;
         F_SEC:          fieldMask = 8'b0000_0011;
         F_YEAR:         fieldMask = 8'b0000_1111;
         default:        fieldMask = 8'b0000_0000;
      endcase
      blank_mask = show_date ? 8'b0000_0000 : 8'b0000_1100;
      if (inEdit && !blinkPhase_q) begin
         blank_mask = blank_mask | fieldMask;
      end
   end

   assign set_valid = setValid_q;
   assign set_sec   = secShadow_q;
   assign set_min   = minShadow_q;
   assign set_hour  = hourShadow_q;
   assign set_day   = dayShadow_q;
   assign set_month = monthShadow_q;
   assign set_year  = yearShadow_q;

endmodule
